// File: rtl/seg_scan_ctrl.sv
// Avalon-MM six-digit multiplexed 7-segment scan controller with dead-time blanking.
// Optional leading-zero blanking via `define SEG_LEADING_ZERO_BLANK_EN (CTRL[1]).
module seg_scan_ctrl #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  avl_address,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic        avl_read,
  output logic [31:0] avl_readdata,
  output logic [5:0]  sel,
  output logic [7:0]  seg_led
);

  localparam int unsigned DWELL_CYC = CLK_FREQ / SCAN_HZ;
  localparam int unsigned SHOW_CYC  = DWELL_CYC - BLANK_CYC;
  localparam int unsigned CNT_W     = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_snap_ld;
  logic [23:0]      r_data;
  logic             r_en;
  logic [5:0]       r_dp, r_den;
  logic [3:0]       r_snap_nib;
  logic             r_snap_dp, r_snap_den, r_snap_blank;
  logic [5:0]       w_sel_nxt;
  logic [7:0]       w_seg_nxt;
  logic [31:0]      w_rdata_nxt;
  logic [3:0]       w_nib;
  logic             w_dp_bit, w_den_bit, w_lzb_blank;
  logic [31:0]      w_ctrl_rd;
  logic             w_unused_wdata;

  assign w_unused_wdata = ^avl_writedata[31:24];

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0: seg_enc = 7'h40;  4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;  4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;  4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;  4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;  4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;  4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;  4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;  default: seg_enc = 7'h0E;
    endcase
  endfunction

  assign w_nib     = 4'(r_data >> {r_idx, 2'b00});
  assign w_dp_bit  = 1'(r_dp >> r_idx);
  assign w_den_bit = 1'(r_den >> r_idx);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic r_lzb;
  // Digit idx is a leading zero when it and every higher nibble are zero.
  assign w_lzb_blank = r_lzb && (r_idx != 3'd0) && ((r_data >> {r_idx, 2'b00}) == 24'd0);
  assign w_ctrl_rd   = {30'd0, r_lzb, r_en};
`else
  assign w_lzb_blank = 1'b0;
  assign w_ctrl_rd   = {31'd0, r_en};
`endif

  // Next-state and next-output logic; outputs follow the current state one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_snap_ld   = 1'b0;
    w_sel_nxt   = 6'h3F;
    w_seg_nxt   = 8'hFF;
    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_state_nxt = S_BLANK;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
        end
      end
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
          w_snap_ld   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SHOW: begin
        if (!r_snap_blank) begin
          if (r_snap_den) w_sel_nxt = ~(6'b1 << r_idx);
          w_seg_nxt = {~r_snap_dp, seg_enc(r_snap_nib)};
        end
        if (r_cnt == SHOW_LAST) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!r_en) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = '0;
      w_snap_ld   = 1'b0;
    end
  end

  always_comb begin
    case (avl_address)
      3'd0:    w_rdata_nxt = {8'd0, r_data};
      3'd1:    w_rdata_nxt = w_ctrl_rd;
      3'd2:    w_rdata_nxt = {26'd0, r_dp};
      3'd3:    w_rdata_nxt = {26'd0, r_den};
      3'd4:    w_rdata_nxt = {23'd0, (r_state != S_IDLE), 5'd0, r_idx};
      default: w_rdata_nxt = 32'd0;
    endcase
  end

  // Scan state, snapshot and display output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_cnt        <= '0;
      r_snap_nib   <= 4'd0;
      r_snap_dp    <= 1'b0;
      r_snap_den   <= 1'b0;
      r_snap_blank <= 1'b0;
      sel          <= 6'h3F;
      seg_led      <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      sel     <= w_sel_nxt;
      seg_led <= w_seg_nxt;
      if (w_snap_ld) begin
        r_snap_nib   <= w_nib;
        r_snap_dp    <= w_dp_bit;
        r_snap_den   <= w_den_bit;
        r_snap_blank <= w_lzb_blank;
      end
    end
  end

  // Register file and read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= 24'd0;
      r_en         <= 1'b0;
      r_dp         <= 6'd0;
      r_den        <= 6'h3F;
      avl_readdata <= 32'd0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      r_lzb        <= 1'b0;
`endif
    end else begin
      if (avl_read) avl_readdata <= w_rdata_nxt;
      if (avl_write) begin
        case (avl_address)
          3'd0: r_data <= avl_writedata[23:0];
          3'd1: begin
            r_en <= avl_writedata[0];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            r_lzb <= avl_writedata[1];
`endif
          end
          3'd2: r_dp  <= avl_writedata[5:0];
          3'd3: r_den <= avl_writedata[5:0];
          default: ;
        endcase
      end
    end
  end

endmodule
